uart_rx_oversample: RTL and testbench
=====================================

UART_RX_OVERSAMPLE -- requirements
Module: uart_rx_oversample

Interface
REQ-001 Parameter clk_freq, default 1E6, system clock frequency in Hz.
REQ-002 Parameter baud, default 9600, serial bit rate in bits/s.
REQ-003 Parameter oversample, default 16, sample ticks per bit; it SHALL be an even value of at least 8.
REQ-004 clk  input  1  system clock; all logic SHALL be on its rising edge, with one clock only.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 rx  input  1  serial line, asynchronous to clk, idle high.
REQ-007 dout_rx  output  8  last correctly framed received byte.
REQ-008 done_rx  output  1  one-clk pulse when dout_rx is updated.
REQ-009 frame_err  output  1  one-clk pulse when the stop bit is sampled low.
REQ-010 busy  output  1  high in any state other than IDLE.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer (rx_s) before any use, giving 2 clk of latency.
REQ-012 Tick divider: DIV = clk_freq/(baud*oversample) using integer truncation (defaults give 6), with a minimum of 1; a one-clk tick fires every DIV clk.
REQ-013 The divider and the sample counter (0..oversample-1) SHALL be cleared when a start edge is detected, so sampling is phase-aligned to the edge.
REQ-014 States SHALL be IDLE, START, DATA, STOP and WAIT_IDLE, with a 3-bit encoding.
REQ-015 Bit value SHALL be the majority of rx_s at sample ticks M-1, M and M+1, where M = oversample/2.
REQ-016 IDLE -> START SHALL occur on the first clk where rx_s = 0, provided rx_s was 1 on the previous clk.
REQ-017 In START, a majority of 1 at tick M+1 is a false start: the block SHALL return to IDLE with no outputs asserted.
REQ-018 START -> DATA SHALL occur at sample-counter wrap (tick oversample-1).
REQ-019 DATA SHALL shift in 8 bits LSB first, one per bit period, and go to STOP after bit 7 wraps.
REQ-020 In STOP, the decision SHALL be made at tick M+1, without waiting for the full stop bit.
REQ-021 STOP with majority 1: on the next clk, dout_rx loads the shifted byte, done_rx = 1 for exactly 1 clk, and the state goes to IDLE.
REQ-022 STOP with majority 0: frame_err = 1 for 1 clk, dout_rx is unchanged, done_rx stays 0, and the state goes to WAIT_IDLE.
REQ-023 WAIT_IDLE -> IDLE SHALL occur once rx_s = 1 for one full bit period of oversample ticks, so break conditions never produce frames.
REQ-024 Back-to-back frames with zero idle gap SHALL be received without loss, because the return to IDLE at the stop-bit midpoint leaves half a bit for edge detection.
REQ-025 dout_rx SHALL hold its value until the next good frame; it has no acknowledge and does not detect overrun.
REQ-026 done_rx and frame_err SHALL never be asserted on the same clk.
REQ-027 An rx glitch that is low for less than oversample/2 ticks SHALL NOT produce done_rx or frame_err.

Reset
REQ-028 While rst_n = 0: state = IDLE, dout_rx = 8'h00, done_rx = 0, frame_err = 0, busy = 0, and the synchronizer flops = 1, taking effect immediately without waiting for clk.
REQ-029 Reset asserted mid-frame SHALL abort the frame; after release, the block SHALL wait for a fresh 1 -> 0 edge and SHALL NOT emit a partial byte.

Verification
REQ-030 Defaults, rx driven with 0xA5 at 96 clk/bit, 1 stop bit -> one done_rx pulse, dout_rx = 8'hA5, frame_err never asserted.
REQ-031 Bytes 0x00, 0xFF and 0x3C sent back-to-back with no idle gap -> three done_rx pulses with dout_rx = 00, FF, 3C in order.
REQ-032 Frame 0x5A with the stop bit held low, then rx high for 2 bit times -> frame_err pulses once, dout_rx keeps its prior value, and the next 0x81 frame is received correctly.
REQ-033 rx low pulse of 30 clk while idle -> return to IDLE, with done_rx = 0 and frame_err = 0.
REQ-034 rst_n pulsed low at data bit 4 of frame 0x96, then frame 0x69 sent -> no output for 0x96, then done_rx with dout_rx = 8'h69.
REQ-035 Frame 0xC3 sent at baud +/-3% (93 and 99 clk/bit) -> dout_rx = 8'hC3 with no frame_err.

Source files
------------

// File: rtl/uart_rx_oversample.sv
// UART receiver (8N1) with an oversampled bit clock.
// The line is synchronised, then a tick divider and a sample counter that are
// re-aligned on every start edge place three votes around each bit centre.
// Good frames update dout_rx with a one-clk done_rx. A low stop bit gives a
// one-clk frame_err, after which the line must stay high for a full bit
// before the next start edge is accepted.
module uart_rx_oversample #(
    parameter int clk_freq   = 1000000,
    parameter int baud       = 9600,
    parameter int oversample = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] dout_rx,
    output logic       done_rx,
    output logic       frame_err,
    output logic       busy
);

    localparam int DIV_RAW = clk_freq / (baud * oversample);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW      = $clog2(oversample);
    localparam int M       = oversample / 2;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic          rx_meta_q, rx_s_q, rx_prev_q;
    logic [DW-1:0] div_q, div_d;
    logic [SW-1:0] smp_q, smp_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          v0_q, v0_d, v1_q, v1_d;
    logic [7:0]    dout_q, dout_d;
    logic          done_q, done_d;
    logic          ferr_q, ferr_d;

    logic tick, wrap, mid, maj, restart;

    // Vote from the two stored samples plus the live sample at tick M+1.
    assign tick = (div_q == DW'(DIV - 1));
    assign wrap = tick && (smp_q == SW'(oversample - 1));
    assign mid  = tick && (smp_q == SW'(M + 1));
    assign maj  = (v0_q & v1_q) | (v0_q & rx_s_q) | (v1_q & rx_s_q);

    // Two-flop synchroniser plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            div_q   <= '0;
            smp_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            v0_q    <= 1'b1;
            v1_q    <= 1'b1;
            dout_q  <= 8'h00;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            smp_q   <= smp_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            v0_q    <= v0_d;
            v1_q    <= v1_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
        end
    end

    // Next-state logic: timing counters, vote capture and frame sequencing.
    always_comb begin
        state_d = state_q;
        div_d   = tick ? '0 : div_q + DW'(1);
        smp_d   = smp_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        v0_d    = v0_q;
        v1_d    = v1_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
        restart = 1'b0;

        if (tick) begin
            smp_d = wrap ? '0 : smp_q + SW'(1);
            if (smp_q == SW'(M - 1)) v0_d = rx_s_q;
            if (smp_q == SW'(M))     v1_d = rx_s_q;
        end

        case (state_q)
            IDLE: begin
                if (!rx_s_q && rx_prev_q) begin
                    state_d = START;
                    restart = 1'b1;
                end
            end
            START: begin
                if (mid && maj) begin
                    state_d = IDLE;
                end else if (wrap) begin
                    state_d = DATA;
                    bit_d   = 3'd0;
                end
            end
            DATA: begin
                if (mid) shift_d = {maj, shift_q[7:1]};
                if (wrap) begin
                    if (bit_q == 3'd7) state_d = STOP;
                    else               bit_d   = bit_q + 3'd1;
                end
            end
            STOP: begin
                if (mid) begin
                    if (maj) begin
                        dout_d  = shift_q;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_IDLE;
                        restart = 1'b1;
                    end
                end
            end
            WAIT_IDLE: begin
                // Any low sample restarts the full-bit high qualification.
                if (!rx_s_q)   restart = 1'b1;
                else if (wrap) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (restart) begin
            div_d = '0;
            smp_d = '0;
        end
    end

    assign dout_rx   = dout_q;
    assign done_rx   = done_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Directed bench for uart_rx_oversample at default parameters (96 clk/bit).
module tb_uart_rx_oversample;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] dout_rx;
    logic       done_rx;
    logic       frame_err;
    logic       busy;

    int n_assert;
    int n_fail;

    int         done_cnt;
    int         ferr_cnt;
    int         both_cnt;
    int         wide_cnt;
    logic       done_prev;
    logic [7:0] byte_log [0:31];

    int base;

    uart_rx_oversample dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .dout_rx   (dout_rx),
        .done_rx   (done_rx),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output monitor: logs received bytes and pulse-shape anomalies.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_prev <= 1'b0;
        end else begin
            if (done_rx) begin
                if (done_cnt < 32) byte_log[done_cnt] <= dout_rx;
                done_cnt <= done_cnt + 1;
                if (done_prev) wide_cnt <= wide_cnt + 1;
            end
            if (frame_err) ferr_cnt <= ferr_cnt + 1;
            if (done_rx && frame_err) both_cnt <= both_cnt + 1;
            done_prev <= done_rx;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input int cpb, input logic stop_v);
        rx = 1'b0;
        wait_clks(cpb);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_clks(cpb);
        end
        rx = stop_v;
        wait_clks(cpb);
        rx = 1'b1;
    endtask

    initial begin
        logic [7:0] rb;
        n_assert = 0;
        n_fail   = 0;
        done_cnt = 0;
        ferr_cnt = 0;
        both_cnt = 0;
        wide_cnt = 0;
        rst_n    = 1'b0;
        rx       = 1'b1;

        // Reset values hold before any clock edge.
        #2;
        check("rst_dout", 32'(dout_rx), 32'h00);
        check("rst_done", 32'(done_rx), 32'h0);
        check("rst_ferr", 32'(frame_err), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        wait_clks(5);
        rst_n = 1'b1;
        wait_clks(20);
        check("idle_busy", 32'(busy), 32'h0);

        // Single nominal frame.
        send_frame(8'hA5, 96, 1'b1);
        wait_clks(192);
        check("a5_done_cnt", 32'(done_cnt), 32'd1);
        check("a5_byte", 32'(byte_log[0]), 32'hA5);
        check("a5_dout", 32'(dout_rx), 32'hA5);
        check("a5_ferr_cnt", 32'(ferr_cnt), 32'd0);

        // Three frames with no idle gap between them.
        base = done_cnt;
        send_frame(8'h00, 96, 1'b1);
        send_frame(8'hFF, 96, 1'b1);
        send_frame(8'h3C, 96, 1'b1);
        wait_clks(192);
        check("b2b_done_cnt", 32'(done_cnt - base), 32'd3);
        check("b2b_byte0", 32'(byte_log[base]), 32'h00);
        check("b2b_byte1", 32'(byte_log[base + 1]), 32'hFF);
        check("b2b_byte2", 32'(byte_log[base + 2]), 32'h3C);
        check("b2b_ferr_cnt", 32'(ferr_cnt), 32'd0);

        // Stop bit held low: one frame error, output byte untouched.
        base = done_cnt;
        send_frame(8'h5A, 96, 1'b0);
        wait_clks(192);
        check("ferr_cnt", 32'(ferr_cnt), 32'd1);
        check("ferr_no_done", 32'(done_cnt - base), 32'd0);
        check("ferr_dout_kept", 32'(dout_rx), 32'h3C);
        check("ferr_busy", 32'(busy), 32'h0);
        send_frame(8'h81, 96, 1'b1);
        wait_clks(192);
        check("after_ferr_done", 32'(done_cnt - base), 32'd1);
        check("after_ferr_dout", 32'(dout_rx), 32'h81);

        // Short low glitch while idle: false start, no outputs.
        base = done_cnt;
        rx = 1'b0;
        wait_clks(20);
        check("glitch_busy_start", 32'(busy), 32'h1);
        wait_clks(10);
        rx = 1'b1;
        wait_clks(192);
        check("glitch_busy_idle", 32'(busy), 32'h0);
        check("glitch_no_done", 32'(done_cnt - base), 32'd0);
        check("glitch_no_ferr", 32'(ferr_cnt), 32'd1);

        // Reset in the middle of data bit 4 of 0x96, held until the stop bit.
        base = done_cnt;
        rb = 8'h96;
        rx = 1'b0;
        wait_clks(96);
        for (int i = 0; i < 4; i++) begin
            rx = rb[i];
            wait_clks(96);
        end
        rx = rb[4];
        wait_clks(48);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_dout", 32'(dout_rx), 32'h00);
        check("midrst_done", 32'(done_rx), 32'h0);
        wait_clks(48);
        for (int i = 5; i < 8; i++) begin
            rx = rb[i];
            wait_clks(96);
        end
        rx = 1'b1;
        wait_clks(48);
        rst_n = 1'b1;
        wait_clks(240);
        check("midrst_no_done", 32'(done_cnt - base), 32'd0);
        check("midrst_no_ferr", 32'(ferr_cnt), 32'd1);
        send_frame(8'h69, 96, 1'b1);
        wait_clks(192);
        check("post_rst_done", 32'(done_cnt - base), 32'd1);
        check("post_rst_dout", 32'(dout_rx), 32'h69);

        // Baud tolerance: fast (93) and slow (99) clk/bit.
        base = done_cnt;
        send_frame(8'hC3, 93, 1'b1);
        wait_clks(192);
        check("fast_done", 32'(done_cnt - base), 32'd1);
        check("fast_dout", 32'(dout_rx), 32'hC3);
        send_frame(8'h3C, 96, 1'b1);
        wait_clks(192);
        send_frame(8'hC3, 99, 1'b1);
        wait_clks(192);
        check("slow_done", 32'(done_cnt - base), 32'd3);
        check("slow_dout", 32'(dout_rx), 32'hC3);
        check("tol_no_ferr", 32'(ferr_cnt), 32'd1);

        // Pulse-shape invariants gathered over the whole run.
        check("done_ferr_overlap", 32'(both_cnt), 32'd0);
        check("done_wide", 32'(wide_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
